morse_char_buffer: RTL
======================

# morse_char_buffer

Decode-and-buffer stage directly downstream of the Morse sequence separator. Each completed 10-bit symbol sequence is decoded to an ASCII character. The character, together with word-space and end-of-message markers, is stored in a first-word-fall-through FIFO. The FIFO is drained by the display/serial output stage. Runs on the same divided clock as the separator.

## Interface

Parameters:
- DEPTH, 16 — FIFO entries; power of two.
- AW, 4 — pointer width, log2(DEPTH).

Ports:
- clk  in  1  — divided system clock, rising edge.
- Reset  in  1  — asynchronous, active-high; clears all state.
- SeqIn  in  10  — encoded sequence from the separator; 5 symbols × 2 bits.
  - First symbol in [9:8], left-justified.
  - Symbol codes: 00 = none, 01 = dot, 10 = dash, 11 = invalid.
- SeqValid  in  1  — one-cycle strobe; SeqIn is complete this cycle.
- WordSpace  in  1  — one-cycle strobe; append space (0x20).
- EndMsg  in  1  — one-cycle strobe; append line feed (0x0A) and signal message end.
- Clear  in  1  — synchronous flush of FIFO and flags.
- RdEn  in  1  — consumer pops head entry at this edge.
- CharOut  out  8  — head entry ASCII; 0x00 when Empty.
- Empty  out  1  — FIFO holds no entries.
- Full  out  1  — Count == DEPTH.
- Count  out  AW+1  — number of stored entries.
- Overflow  out  1  — sticky; a write was dropped because the FIFO was full.
- MsgDone  out  1  — one-cycle pulse when the 0x0A entry is written.

## Operation

- **Reset values:** CharOut = 0x00, Empty = 1, Full = 0, Count = 0, Overflow = 0, MsgDone = 0; pointers = 0; pipeline register invalid.
- **Stage 1 (decode register):** at each edge, latch one write request, chosen by priority:
  - Clear > SeqValid > WordSpace > EndMsg.
  - Lower-priority strobes in the same cycle are discarded without effect.
- **Decode rules:**
  - ITU Morse A–Z → 0x41–0x5A; digits 0–9 → 0x30–0x39.
  - Examples: A = 0x180, E = 0x100, S = 0x150, 0 = 0x2AA.
  - Any 11 symbol, a 00 followed by a non-00 symbol, or an unlisted pattern → 0x3F ('?').
  - SeqIn = 0x000 with SeqValid produces no request.
- **Stage 2 (write):** a valid stage-1 request writes mem[wr_ptr]; wr_ptr advances modulo DEPTH.
  - If Full and RdEn is not asserted in the same cycle, the write is dropped and Overflow is set.
  - If Full and RdEn is asserted, both the read and the write proceed and Count stays DEPTH.
- **Read:** RdEn with !Empty advances rd_ptr modulo DEPTH; RdEn while Empty is ignored.
- **Count:**
  - +1 on write only; −1 on read only; unchanged when both or neither occur.
  - Empty = (Count == 0); Full = (Count == DEPTH); both derived from registered Count.
- **Clear:**
  - At the edge: pointers, Count, Overflow and the stage-1 register are zeroed.
  - A stage-2 write pending at that edge is discarded; a read at that edge is ignored.
- **MsgDone:** registered pulse, high for the one cycle after the 0x0A entry is actually written. No pulse if that write is dropped.
- **Pointer wrap:** pointers wrap from DEPTH−1 to 0 with no data corruption; ordering is strictly FIFO.

## Timing

- Strobe sampled at edge E → stage-1 register valid after E → memory write, Count and Empty update at edge E+1.
- Character visible on CharOut after E+1: two-cycle latency.
- **Back-to-back strobes:** one per cycle is sustained at full throughput.
- **CharOut:** combinational from mem[rd_ptr] gated by !Empty; updates in the cycle after a pop.
- **Overflow:** asserted after the edge that drops a write; cleared only by Clear or Reset.
- **Reset mid-operation:** takes effect immediately and asynchronously. Outputs return to reset values with no partial write; operation resumes at the first edge after Reset deasserts.

## Test plan

- **Decode:** after Reset, pulse SeqValid with SeqIn = 0x180, then 0x100, then 0x2AA on consecutive cycles.
  - Required: Empty falls two cycles after the first strobe; reads return 0x41, 0x45, 0x30; Count goes 1, 2, 3, then drains to 0.
- **Invalid patterns:** SeqIn = 0x300 (11 symbol) and 0x040 (gap before symbol).
  - Required: both produce 0x3F. SeqIn = 0x000 leaves Count unchanged.
- **Full / overflow:** write 17 'S' (0x150) with no reads.
  - Required: Full = 1 and Count = 16 after the 16th write; 17th dropped and Overflow = 1.
  - Then pop 16: all 0x53, Empty = 1, Overflow still 1 until Clear.
- **Full with simultaneous pop:** with the FIFO full, assert RdEn on the same edge a write lands.
  - Required: Count stays 16, Overflow stays 0, order preserved across pointer wrap.
- **Priority and markers:** assert SeqValid (0x180) + WordSpace + EndMsg in one cycle.
  - Required: only 0x41 stored.
  - Then WordSpace, then EndMsg: entries 0x20, 0x0A; MsgDone pulses one cycle, coincident with Count incrementing for 0x0A.
- **Clear and Reset mid-stream:** Clear in the same cycle as SeqValid, with one write pending.
  - Required: Count = 0, Empty = 1, nothing stored.
  - Async Reset mid-cycle: all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/morse_char_buffer_if.sv
// Decode/buffer stage bus: separator strobes in, FIFO head and status out.
// The master side drives strobes and RdEn; the slave side is the buffer.
interface morse_char_buffer_if #(
  parameter int unsigned AW = 4
);
  logic [9:0]  SeqIn;
  logic        SeqValid;
  logic        WordSpace;
  logic        EndMsg;
  logic        Clear;
  logic        RdEn;
  logic [7:0]  CharOut;
  logic        Empty;
  logic        Full;
  logic [AW:0] Count;
  logic        Overflow;
  logic        MsgDone;

  modport master (
    output SeqIn, SeqValid, WordSpace, EndMsg, Clear, RdEn,
    input  CharOut, Empty, Full, Count, Overflow, MsgDone
  );

  modport slave (
    input  SeqIn, SeqValid, WordSpace, EndMsg, Clear, RdEn,
    output CharOut, Empty, Full, Count, Overflow, MsgDone
  );
endinterface

// File: rtl/morse_char_buffer.sv
// Decodes 10-bit Morse sequences to ASCII and queues them, with space/LF markers,
// in a first-word-fall-through FIFO read by the output stage.
module morse_char_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic                clk,
  input logic                Reset,
  morse_char_buffer_if.slave bus
);

  localparam logic [AW:0] DepthCount = (AW + 1)'(DEPTH);

  // Canonical key: symbol count plus dash bits (dash = 1), first symbol most significant.
  function automatic logic [7:0] decodeSeq(input logic [9:0] seq);
    logic [2:0] len;
    logic [4:0] bits;
    logic [1:0] sym;
    logic       bad;
    logic       gap;
    len  = '0;
    bits = '0;
    bad  = 1'b0;
    gap  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sym = seq[9 - 2 * i -: 2];
      if (sym == 2'b11) begin
        bad = 1'b1;
      end else if (sym == 2'b00) begin
        gap = 1'b1;
      end else begin
        if (gap) bad = 1'b1;
        len  = len + 3'd1;
        bits = {bits[3:0], sym[1]};
      end
    end
    if (bad) return 8'h3F;
    case ({len, bits})
      {3'd2, 5'b00001}: return 8'h41; // A
      {3'd4, 5'b01000}: return 8'h42; // B
      {3'd4, 5'b01010}: return 8'h43; // C
      {3'd3, 5'b00100}: return 8'h44; // D
      {3'd1, 5'b00000}: return 8'h45; // E
      {3'd4, 5'b00010}: return 8'h46; // F
      {3'd3, 5'b00110}: return 8'h47; // G
      {3'd4, 5'b00000}: return 8'h48; // H
      {3'd2, 5'b00000}: return 8'h49; // I
      {3'd4, 5'b00111}: return 8'h4A; // J
      {3'd3, 5'b00101}: return 8'h4B; // K
      {3'd4, 5'b00100}: return 8'h4C; // L
      {3'd2, 5'b00011}: return 8'h4D; // M
      {3'd2, 5'b00010}: return 8'h4E; // N
      {3'd3, 5'b00111}: return 8'h4F; // O
      {3'd4, 5'b00110}: return 8'h50; // P
      {3'd4, 5'b01101}: return 8'h51; // Q
      {3'd3, 5'b00010}: return 8'h52; // R
      {3'd3, 5'b00000}: return 8'h53; // S
      {3'd1, 5'b00001}: return 8'h54; // T
      {3'd3, 5'b00001}: return 8'h55; // U
      {3'd4, 5'b00001}: return 8'h56; // V
      {3'd3, 5'b00011}: return 8'h57; // W
      {3'd4, 5'b01001}: return 8'h58; // X
      {3'd4, 5'b01011}: return 8'h59; // Y
      {3'd4, 5'b01100}: return 8'h5A; // Z
      {3'd5, 5'b11111}: return 8'h30;
      {3'd5, 5'b01111}: return 8'h31;
      {3'd5, 5'b00111}: return 8'h32;
      {3'd5, 5'b00011}: return 8'h33;
      {3'd5, 5'b00001}: return 8'h34;
      {3'd5, 5'b00000}: return 8'h35;
      {3'd5, 5'b10000}: return 8'h36;
      {3'd5, 5'b11000}: return 8'h37;
      {3'd5, 5'b11100}: return 8'h38;
      {3'd5, 5'b11110}: return 8'h39;
      default:          return 8'h3F;
    endcase
  endfunction

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wrPtrQ, rdPtrQ;
  logic [AW:0] countQ;
  logic        overflowQ, msgDoneQ;
  logic        stValidQ;
  logic [7:0]  stCharQ;
  logic        empty, full, doRead, doWrite, dropWrite;

  // Stage 1: one request per edge, highest-priority strobe wins.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stValidQ <= 1'b0;
      stCharQ  <= 8'h00;
    end else if (bus.Clear) begin
      stValidQ <= 1'b0;
      stCharQ  <= 8'h00;
    end else if (bus.SeqValid) begin
      stValidQ <= (bus.SeqIn != 10'h000);
      stCharQ  <= decodeSeq(bus.SeqIn);
    end else if (bus.WordSpace) begin
      stValidQ <= 1'b1;
      stCharQ  <= 8'h20;
    end else if (bus.EndMsg) begin
      stValidQ <= 1'b1;
      stCharQ  <= 8'h0A;
    end else begin
      stValidQ <= 1'b0;
    end
  end

  always_comb begin
    empty     = (countQ == '0);
    full      = (countQ == DepthCount);
    doRead    = bus.RdEn && !empty && !bus.Clear;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
    doWrite   = stValidQ && (!full || bus.RdEn) && !bus.Clear;
    dropWrite = stValidQ && full && !bus.RdEn && !bus.Clear;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
      msgDoneQ  <= 1'b0;
    end else if (bus.Clear) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
      msgDoneQ  <= 1'b0;
    end else begin
      if (doWrite) wrPtrQ <= wrPtrQ + 1'b1;
      if (doRead)  rdPtrQ <= rdPtrQ + 1'b1;
      if (doWrite && !doRead) begin
        countQ <= countQ + 1'b1;
      end else if (doRead && !doWrite) begin
        countQ <= countQ - 1'b1;
      end
      if (dropWrite) overflowQ <= 1'b1;
      msgDoneQ <= doWrite && (stCharQ == 8'h0A);
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtrQ] <= stCharQ;
  end

  assign bus.CharOut  = empty ? 8'h00 : mem[rdPtrQ];
  assign bus.Empty    = empty;
  assign bus.Full     = full;
  assign bus.Count    = countQ;
  assign bus.Overflow = overflowQ;
  assign bus.MsgDone  = msgDoneQ;

endmodule
